// File: rtl/hue_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hue_pkg
// Description : Shared types and width helpers for the hue sequencer slice.
//               - mode_e : runtime operating mode (CYCLE / HOLD / BREATHE / OFF)
//               - dir_e  : ramp direction used while breathing
//               - phase_width / presc_width : counter width helpers
// Revision    : 1.0 - initial release
// ============================================================================
package hue_pkg;

    localparam int c_mode_w = 2;

    typedef enum logic [c_mode_w-1:0] {
        MODE_CYCLE   = 2'b00,
        MODE_HOLD    = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Width of the wheel phase counter: the wheel has 2*channels phases.
    function automatic int phase_width(input int channels);
        return (channels > 1) ? $clog2(2 * channels) : 1;
    endfunction

    // Width of the step prescaler; at least one bit even for a divide-by-1.
    function automatic int presc_width(input int step_cycles);
        return (step_cycles > 1) ? $clog2(step_cycles) : 1;
    endfunction

endpackage : hue_pkg
`default_nettype wire

// File: rtl/hue_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hue_sequencer_if
// Description : Control/status bundle of the hue sequencer.
//               master : drives mode and breathe_mask, observes status/LEDs
//               slave  : the sequencer itself
//               Signals: mode, breathe_mask[CHANNELS], led[CHANNELS],
//                        phase[phase_width(CHANNELS)], level[PWM_BITS],
//                        cycle_done
// Revision    : 1.0 - initial release
// ============================================================================
interface hue_sequencer_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) ();

    localparam int c_phase_w = hue_pkg::phase_width(CHANNELS);

    hue_pkg::mode_e         mode;
    logic [CHANNELS-1:0]    breathe_mask;
    logic [CHANNELS-1:0]    led;
    logic [c_phase_w-1:0]   phase;
    logic [PWM_BITS-1:0]    level;
    logic                   cycle_done;

    modport master (
        output mode,
        output breathe_mask,
        input  led,
        input  phase,
        input  level,
        input  cycle_done
    );

    modport slave (
        input  mode,
        input  breathe_mask,
        output led,
        output phase,
        output level,
        output cycle_done
    );

endinterface : hue_sequencer_if
`default_nettype wire

// File: rtl/hue_sequencer_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_bank
// Description : Shared free-running PWM counter with one duty comparator per
//               channel and a registered LED output stage.
//               clk, rst_n      : clock, synchronous active-low reset
//               duty[CHANNELS]  : per-channel duty, 0 = off, all-ones = on
//               enable          : 0 forces all LEDs low on the next edge
//               led[CHANNELS]   : registered PWM outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty [CHANNELS],
    input  logic                enable,
    output logic [CHANNELS-1:0] led
);

    localparam logic [PWM_BITS-1:0] c_level_max = '1;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [CHANNELS-1:0] w_on;
    logic [CHANNELS-1:0] r_led;

    // Counter wraps naturally at 2**PWM_BITS-1 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Full-scale duty is forced on so the top level is a true 100 %, not
    // (2**PWM_BITS-1)/2**PWM_BITS.
    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            assign w_on[k] = (duty[k] == c_level_max) || (r_pwm_cnt < duty[k]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= enable ? w_on : '0;
        end
    end

    assign led = r_led;

endmodule : pwm_bank
`default_nettype wire

// File: rtl/hue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hue_sequencer
// Description : N-channel colour-wheel LED driver. A prescaler produces a
//               level step every STEP_CYCLES clocks; the ramp/phase logic
//               walks 2*CHANNELS hue phases (CYCLE) or a triangle wave
//               (BREATHE), and a PWM bank turns the resulting per-channel
//               duties into LED pulses.
//               clk    : system clock
//               rst_n  : synchronous reset, active low
//               bus    : hue_sequencer_if.slave (mode, breathe_mask in;
//                        led, phase, level, cycle_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module hue_sequencer
    import hue_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 7812
) (
    input  logic           clk,
    input  logic           rst_n,
    hue_sequencer_if.slave bus
);

    localparam int c_phase_w = phase_width(CHANNELS);
    localparam int c_presc_w = presc_width(STEP_CYCLES);

    localparam logic [PWM_BITS-1:0]  c_level_max  = '1;
    localparam logic [PWM_BITS-1:0]  c_level_one  = PWM_BITS'(1);
    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(2 * CHANNELS - 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(STEP_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [c_presc_w-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_level;
    logic [c_phase_w-1:0] r_phase;
    dir_e                 r_dir;
    mode_e                r_mode_q;
    mode_e                r_pat;        // last non-HOLD mode, selects duty pattern
    logic                 r_cycle_done;

    logic [c_presc_w-1:0] w_presc_nxt;
    logic [PWM_BITS-1:0]  w_level_nxt;
    logic [c_phase_w-1:0] w_phase_nxt;
    dir_e                 w_dir_nxt;
    logic                 w_done_nxt;
    logic                 w_tick;
    logic                 w_clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_level      <= '0;
            r_phase      <= '0;
            r_dir        <= DIR_UP;
            r_mode_q     <= MODE_CYCLE;
            r_pat        <= MODE_CYCLE;
            r_cycle_done <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_level      <= w_level_nxt;
            r_phase      <= w_phase_nxt;
            r_dir        <= w_dir_nxt;
            r_mode_q     <= bus.mode;
            r_cycle_done <= w_done_nxt;
            if (bus.mode != MODE_HOLD) begin
                r_pat <= bus.mode;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ramp / phase next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_presc_nxt = r_presc;
        w_level_nxt = r_level;
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;

        w_tick = (r_presc == c_presc_last);

        // A switch among CYCLE/BREATHE/OFF restarts from a clean state; moves
        // into or out of HOLD keep the frozen state. OFF clears continuously.
        w_clear = (bus.mode == MODE_OFF) ||
                  ((bus.mode != r_mode_q) &&
                   (bus.mode != MODE_HOLD) && (r_mode_q != MODE_HOLD));

        if (w_clear) begin
            w_presc_nxt = '0;
            w_level_nxt = '0;
            w_phase_nxt = '0;
            w_dir_nxt   = DIR_UP;
        end else begin
            unique case (bus.mode)
                MODE_CYCLE: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_level == c_level_max) begin
                            w_level_nxt = '0;
                            if (r_phase == c_phase_last) begin
                                w_phase_nxt = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_phase_nxt = r_phase + 1'b1;
                            end
                        end else begin
                            w_level_nxt = r_level + 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    w_phase_nxt = '0;
                    if (w_tick) begin
                        // Saturating moves keep the ramp in range even when
                        // BREATHE resumes out of HOLD at an arbitrary level.
                        if (r_dir == DIR_UP) begin
                            if (r_level != c_level_max) begin
                                w_level_nxt = r_level + 1'b1;
                            end
                            if (r_level >= c_level_max - c_level_one) begin
                                w_dir_nxt = DIR_DOWN;
                            end
                        end else begin
                            if (r_level != '0) begin
                                w_level_nxt = r_level - 1'b1;
                            end
                            if (r_level <= c_level_one) begin
                                w_dir_nxt  = DIR_UP;
                                w_done_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // HOLD: everything frozen (OFF is covered by w_clear).
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Duty mux
    // ------------------------------------------------------------------------
    logic [PWM_BITS-1:0] w_duty [CHANNELS];
    mode_e               w_pat;
    logic                w_enable;
    int                  w_chan_a;
    int                  w_chan_b;

    always_comb begin
        // While held, the pattern of the mode that was running is kept.
        w_pat    = (bus.mode == MODE_HOLD) ? r_pat : bus.mode;
        w_enable = (w_pat != MODE_OFF);

        // Phase 2k fades channel k+1 in over a full channel k; phase 2k+1
        // fades channel k out under a full channel k+1.
        w_chan_a = int'(r_phase >> 1);
        w_chan_b = (w_chan_a == CHANNELS - 1) ? 0 : w_chan_a + 1;

        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_duty[ch] = '0;
            if (w_pat == MODE_BREATHE) begin
                if (bus.breathe_mask[ch]) begin
                    w_duty[ch] = r_level;
                end
            end else if (w_pat == MODE_CYCLE) begin
                if (ch == w_chan_a) begin
                    w_duty[ch] = r_phase[0] ? (c_level_max - r_level) : c_level_max;
                end else if (ch == w_chan_b) begin
                    w_duty[ch] = r_phase[0] ? c_level_max : r_level;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // PWM bank and outputs
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] w_led;

    pwm_bank #(
        .CHANNELS (CHANNELS),
        .PWM_BITS (PWM_BITS)
    ) u_pwm_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (w_duty),
        .enable (w_enable),
        .led    (w_led)
    );

    assign bus.led        = w_led;
    assign bus.phase      = r_phase;
    assign bus.level      = r_level;
    assign bus.cycle_done = r_cycle_done;

endmodule : hue_sequencer
`default_nettype wire

// File: tb/tb_hue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hue_sequencer
// Description : Directed self-checking bench for hue_sequencer with
//               CHANNELS=3, PWM_BITS=3, STEP_CYCLES=2 (LEVEL_MAX=7, 16 clk
//               per phase). A table of hand-computed wheel vectors is followed
//               by sequences for HOLD, BREATHE, OFF and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hue_sequencer;
    import hue_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hue_sequencer_if #(.CHANNELS(3), .PWM_BITS(3)) bus ();

    hue_sequencer #(
        .CHANNELS    (3),
        .PWM_BITS    (3),
        .STEP_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int edges    = 0;   // released clock edges since the last reset
    int done_cnt = 0;

    typedef struct {
        int         n;      // released edges since reset
        logic [2:0] led;
        int         phase;
        int         level;
        logic       done;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            if (rst_n) edges++;
            if (bus.cycle_done === 1'b1) done_cnt++;
        end
    endtask

    function automatic int tri_level(input int t);
        int r;
        r = t % 14;
        return (r <= 7) ? r : 14 - r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int cur;
        int ones0, ones1, ones2;
        int lv, lv_prev, cnt_prev;
        logic on;

        //            n   led     ph lv done
        tbl[0]  = '{  1, 3'b001, 0, 0, 1'b0};
        tbl[1]  = '{  7, 3'b001, 0, 3, 1'b0};
        tbl[2]  = '{ 10, 3'b011, 0, 5, 1'b0};
        tbl[3]  = '{ 16, 3'b011, 1, 0, 1'b0};
        tbl[4]  = '{ 17, 3'b011, 1, 0, 1'b0};
        tbl[5]  = '{ 29, 3'b010, 1, 6, 1'b0};
        tbl[6]  = '{ 31, 3'b010, 1, 7, 1'b0};
        tbl[7]  = '{ 37, 3'b010, 2, 2, 1'b0};
        tbl[8]  = '{ 41, 3'b110, 2, 4, 1'b0};
        tbl[9]  = '{ 50, 3'b110, 3, 1, 1'b0};
        tbl[10] = '{ 60, 3'b100, 3, 6, 1'b0};
        tbl[11] = '{ 70, 3'b100, 4, 3, 1'b0};
        tbl[12] = '{ 73, 3'b101, 4, 4, 1'b0};
        tbl[13] = '{ 90, 3'b101, 5, 5, 1'b0};
        tbl[14] = '{ 95, 3'b001, 5, 7, 1'b0};
        tbl[15] = '{ 96, 3'b001, 0, 0, 1'b1};
        tbl[16] = '{ 97, 3'b001, 0, 0, 1'b0};

        bus.mode         = MODE_CYCLE;
        bus.breathe_mask = 3'b000;
        rst_n            = 1'b0;

        // ---- reset ----
        step(3);
        check("reset.led",   {29'b0, bus.led},   0);
        check("reset.phase", {29'b0, bus.phase}, 0);
        check("reset.level", {29'b0, bus.level}, 0);
        check("reset.done",  {31'b0, bus.cycle_done}, 0);

        // ---- full wheel from table ----
        rst_n    = 1'b1;
        edges    = 0;
        done_cnt = 0;
        cur      = 0;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].n - cur);
            cur = tbl[i].n;
            check($sformatf("wheel[n=%0d].led", cur),   {29'b0, bus.led},   {29'b0, tbl[i].led});
            check($sformatf("wheel[n=%0d].phase", cur), {29'b0, bus.phase}, tbl[i].phase);
            check($sformatf("wheel[n=%0d].level", cur), {29'b0, bus.level}, tbl[i].level);
            check($sformatf("wheel[n=%0d].done", cur),  {31'b0, bus.cycle_done}, {31'b0, tbl[i].done});
        end
        check("wheel.done_count", done_cnt, 1);

        // ---- HOLD at phase 2 level 4 ----
        step(136 - 97);
        check("prehold.phase", {29'b0, bus.phase}, 2);
        check("prehold.level", {29'b0, bus.level}, 4);
        bus.mode = MODE_HOLD;
        step(50);
        check("hold.phase", {29'b0, bus.phase}, 2);
        check("hold.level", {29'b0, bus.level}, 4);
        ones0 = 0; ones1 = 0; ones2 = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            ones0 += int'(bus.led[0]);
            ones1 += int'(bus.led[1]);
            ones2 += int'(bus.led[2]);
        end
        check("hold.led0_ones", ones0, 0);
        check("hold.led1_ones", ones1, 16);
        check("hold.led2_ones", ones2, 8);
        check("hold.level_after", {29'b0, bus.level}, 4);
        bus.mode = MODE_CYCLE;
        step(1);
        check("resume1.level", {29'b0, bus.level}, 4);
        check("resume1.phase", {29'b0, bus.phase}, 2);
        step(1);
        check("resume2.level", {29'b0, bus.level}, 5);

        // ---- BREATHE, mask 101 ----
        bus.breathe_mask = 3'b101;
        bus.mode         = MODE_BREATHE;
        step(1);
        check("breathe0.level", {29'b0, bus.level}, 0);
        check("breathe0.phase", {29'b0, bus.phase}, 0);
        for (int j = 1; j <= 60; j++) begin
            step(1);
            lv       = tri_level(j / 2);
            lv_prev  = tri_level((j - 1) / 2);
            cnt_prev = (edges - 1) % 8;
            on       = (lv_prev == 7) || (cnt_prev < lv_prev);
            check($sformatf("breathe[%0d].level", j), {29'b0, bus.level}, lv);
            check($sformatf("breathe[%0d].phase", j), {29'b0, bus.phase}, 0);
            check($sformatf("breathe[%0d].done", j),  {31'b0, bus.cycle_done},
                  ((j == 28) || (j == 56)) ? 1 : 0);
            check($sformatf("breathe[%0d].led", j),   {29'b0, bus.led}, {29'b0, on, 1'b0, on});
        end

        // ---- CYCLE (phase 4) -> OFF -> CYCLE ----
        bus.mode = MODE_CYCLE;
        step(1);
        check("cyc_restart.phase", {29'b0, bus.phase}, 0);
        check("cyc_restart.level", {29'b0, bus.level}, 0);
        step(70);
        check("preoff.phase", {29'b0, bus.phase}, 4);
        check("preoff.level", {29'b0, bus.level}, 3);
        bus.mode = MODE_OFF;
        step(1);
        check("off1.led",   {29'b0, bus.led},   0);
        check("off1.phase", {29'b0, bus.phase}, 0);
        check("off1.level", {29'b0, bus.level}, 0);
        check("off1.done",  {31'b0, bus.cycle_done}, 0);
        step(3);
        check("off4.led",   {29'b0, bus.led},   0);
        check("off4.level", {29'b0, bus.level}, 0);
        bus.mode = MODE_CYCLE;
        step(1);
        check("on1.led",   {29'b0, bus.led},   3'b001);
        check("on1.phase", {29'b0, bus.phase}, 0);
        check("on1.level", {29'b0, bus.level}, 0);
        step(1);
        check("on2.level", {29'b0, bus.level}, 0);
        step(1);
        check("on3.level", {29'b0, bus.level}, 1);

        // ---- reset mid phase 3 with step pending ----
        step(53 - 2);
        check("prerst.phase", {29'b0, bus.phase}, 3);
        check("prerst.level", {29'b0, bus.level}, 2);
        rst_n = 1'b0;
        step(1);
        check("midrst.led",   {29'b0, bus.led},   0);
        check("midrst.phase", {29'b0, bus.phase}, 0);
        check("midrst.level", {29'b0, bus.level}, 0);
        check("midrst.done",  {31'b0, bus.cycle_done}, 0);
        rst_n = 1'b1;
        edges = 0;
        step(1);
        check("postrst1.level", {29'b0, bus.level}, 0);
        check("postrst1.led",   {29'b0, bus.led},   3'b001);
        check("postrst1.done",  {31'b0, bus.cycle_done}, 0);
        step(1);
        check("postrst2.level", {29'b0, bus.level}, 1);
        check("postrst2.phase", {29'b0, bus.phase}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hue_sequencer
`default_nettype wire
